// File: rtl/updown_counter_n.sv
// -----------------------------------------------------------------------------
// updown_counter_n
//
// Parametrised synchronous up/down counter. Its count range is 0..MAX. It
// supports a parallel load and two modes, free-running (wrap) and one-shot
// (stop at the terminal value). A small IDLE/RUN/DONE control FSM gates the
// counting. The wrap and done outputs are registered single-cycle pulses.
//
// Parameters
//   WIDTH  counter width in bits (>= 2)
//   MAX    top count value, 1 .. 2**WIDTH-1
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   start    in   enter RUN from IDLE/DONE; latches up and oneshot
//   stop     in   return to IDLE, count held
//   en       in   count enable while in RUN
//   load     in   parallel load of a (saturated to MAX)
//   a        in   load value
//   up       in   direction sampled at start (1 = up)
//   oneshot  in   mode sampled at start (1 = stop at terminal)
//   count    out  current count (registered)
//   busy     out  high while in RUN
//   tc       out  count at terminal value while in RUN
//   wrap     out  one-cycle pulse, free-run wrap happened
//   done     out  one-cycle pulse, one-shot reached terminal
//   ovf      out  sticky wrap flag
//
// Build option
//   UPDOWN_CNT_OVF_EN  When defined, ovf is a sticky flag. A wrap pulse sets
//                      it. Only rst or an accepted start clears it. When not
//                      defined, ovf is tied low and no register is built.
//
// Per-edge priority: rst > load > stop > start > count step.
// -----------------------------------------------------------------------------
module updown_counter_n #(
  parameter int WIDTH = 8,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic             up,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q,   dir_d;    // 1 = counting up
  logic             mode_q,  mode_d;   // 1 = one-shot
  logic             wrap_q,  wrap_d;
  logic             done_q,  done_d;
  logic             at_term;

  // The terminal value depends on the direction latched at start.
  assign at_term = dir_q ? (count_q == MAX_V) : (count_q == '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    if (load) begin
      // Saturate the load so that count never goes above MAX. A load
      // replaces the step for this cycle, so no wrap or done pulse is made.
      count_d = (a > MAX_V) ? MAX_V : a;
    end else if (stop) begin
      state_d = ST_IDLE;
    end else if (start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
      dir_d   = up;
      mode_d  = oneshot;
    end else if ((state_q == ST_RUN) && en) begin
      if (!at_term) begin
        count_d = dir_q ? (count_q + ONE_V) : (count_q - ONE_V);
      end else if (mode_q) begin
        // One-shot: hold at the terminal value and finish.
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        // Free-run: wrap modulo MAX+1, not modulo 2**WIDTH.
        count_d = dir_q ? '0 : MAX_V;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dir_q   <= 1'b1;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

`ifdef UPDOWN_CNT_OVF_EN
  logic ovf_q, ovf_d;
  logic start_acc;

  // The start is accepted only when no load or stop has priority over it
  // and the FSM is not already running.
  assign start_acc = start && !load && !stop && (state_q != ST_RUN);

  always_comb begin
    ovf_d = ovf_q;
    if (start_acc) ovf_d = 1'b0;
    if (wrap_d)    ovf_d = 1'b1;   // same edge as the wrap pulse
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign count = count_q;
  assign busy  = (state_q == ST_RUN);
  assign tc    = (state_q == ST_RUN) && at_term;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule
